// File: rtl/key_stim_pkg.sv
// key_stim_pkg: shared modes, states, LFSR constants and step function for key_stim_gen
package key_stim_pkg;
  localparam int KS_LFSR_W = 16;
  localparam logic [KS_LFSR_W-1:0] KS_LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {KS_RANDOM, KS_INC, KS_FIXED} ks_mode_e;
  typedef enum logic [1:0] {KS_IDLE, KS_WAIT, KS_PRESENT} ks_state_e;
  function automatic logic [KS_LFSR_W-1:0] ks_lfsr_next(input logic [KS_LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? KS_LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/key_stim_lfsr.sv
// key_stim_lfsr: 16-bit Galois LFSR advancing once per cycle with step high
// Ports: clk, rst (sync, active high), step (advance), value (current state).
// A zero SEED would lock the LFSR, so it is replaced by 1.
module key_stim_lfsr
  import key_stim_pkg::*;
#(
  parameter logic [KS_LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [KS_LFSR_W-1:0] value
);
  localparam logic [KS_LFSR_W-1:0] INIT = (SEED == '0) ? KS_LFSR_W'(1) : SEED;
  logic [KS_LFSR_W-1:0] value_q;
  always_ff @(posedge clk)
    value_q <= rst ? INIT : step ? ks_lfsr_next(value_q) : value_q;
  assign value = value_q;
endmodule

// File: rtl/key_stim_gen.sv
// key_stim_gen: keyboard stimulus source with random/inc/fixed data and LFSR or fixed gaps
// Ports: clk, rst (sync, active high), enable, mode (0 random, 1 inc, 2/3 fixed),
//   lat_cfg (gap = lat_cfg+1 in inc/fixed), fixed_data, key_ready (consumer accept),
//   key_in / key_d_en (registered key and valid), sent_count (saturating accepted keys).
// Macro KEY_STIM_CNT_EN: when defined, sent_count is implemented; otherwise tied to 0.
module key_stim_gen
  import key_stim_pkg::*;
#(
  parameter int                   DATA_W = 8,
  parameter int                   LAT_W  = 5,
  parameter logic [KS_LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [LAT_W-1:0]  lat_cfg,
  input  logic [DATA_W-1:0] fixed_data,
  input  logic              key_ready,
  output logic [DATA_W-1:0] key_in,
  output logic              key_d_en,
  output logic [15:0]       sent_count
);
  ks_state_e            state_q, state_d;
  logic [LAT_W:0]       cnt_q, cnt_d, lat;
  logic [DATA_W-1:0]    key_q, key_d, inc_q, rnd, dat;
  logic                 den_q, den_d, step, xfer;
  logic [KS_LFSR_W-1:0] lfsr;
  logic                 unused_lfsr;

  key_stim_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .step(step), .value(lfsr));

  assign unused_lfsr = ^lfsr;
  // Fields are taken from the LFSR value before the step that accompanies each state entry.
  assign lat  = (LAT_W+1)'(mode == KS_RANDOM ? lfsr[LAT_W-1:0] : lat_cfg) + (LAT_W+1)'(1);
  assign rnd  = lfsr[LAT_W+DATA_W-1:LAT_W];
  assign dat  = mode == KS_RANDOM ? (&rnd ? '0 : rnd) : mode == KS_INC ? inc_q : fixed_data;
  assign xfer = den_q && key_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    den_d   = den_q;
    step    = 1'b0;
    case (state_q)
      KS_IDLE: if (enable) begin
        state_d = KS_WAIT;
        cnt_d   = lat;
        step    = 1'b1;
      end
      KS_WAIT: if (!enable) state_d = KS_IDLE;
      else if (cnt_q == (LAT_W+1)'(1)) begin
        state_d = KS_PRESENT;
        key_d   = dat;
        den_d   = 1'b1;
        step    = 1'b1;
      end else cnt_d = cnt_q - (LAT_W+1)'(1);
      KS_PRESENT: if (xfer) begin
        den_d   = 1'b0;
        state_d = enable ? KS_WAIT : KS_IDLE;
        cnt_d   = enable ? lat : cnt_q;
        step    = enable;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      key_q   <= '1;
      den_q   <= 1'b0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      den_q   <= den_d;
      inc_q   <= xfer ? inc_q + DATA_W'(1) : inc_q;
    end

  assign key_in   = key_q;
  assign key_d_en = den_q;

`ifdef KEY_STIM_CNT_EN
  logic [15:0] sent_q;
  always_ff @(posedge clk)
    sent_q <= rst ? '0 : (xfer && !(&sent_q)) ? sent_q + 16'd1 : sent_q;
  assign sent_count = sent_q;
`else
  assign sent_count = '0;
`endif
endmodule

// File: tb/tb_key_stim_gen.sv
// tb_key_stim_gen: directed scoreboard bench for key_stim_gen
module tb_key_stim_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'd1;
  logic [4:0] lat_cfg = 5'd3;
  logic [7:0] fixed_data = 8'h00;
  logic       key_ready = 1'b1;
  logic [7:0] key_in;
  logic       key_d_en;
  logic [15:0] sent_count;

  typedef struct {int gap; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int g;
  int highs;
  logic [15:0] lfsr_m;
  logic [5:0] lm;
  logic [7:0] dm;

  key_stim_gen #(.DATA_W(8), .LAT_W(5), .SEED(16'h0001)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .lat_cfg(lat_cfg),
    .fixed_data(fixed_data), .key_ready(key_ready), .key_in(key_in),
    .key_d_en(key_d_en), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef KEY_STIM_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_key(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!key_d_en && gap < 200);
    check("key_seen", key_d_en, 1);
  endtask

  function automatic logic [15:0] galois(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  initial begin
    // reset held for 3 cycles, then one cycle after release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_den", key_d_en, 0);
      check("rst_key", key_in, 8'hFF);
      check("rst_cnt", sent_count, 0);
    end
    rst = 1'b0;
    tick();
    check("rel_den", key_d_en, 0);
    check("rel_key", key_in, 8'hFF);
    check("rel_cnt", sent_count, 0);

    // INC mode, lat_cfg=3: first key 5 cycles after release, then every 5
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back('{(i == 0) ? 4 : 5, 8'(i)});
      wait_key(g);
      e = exp_q.pop_front();
      check("inc_gap", g, e.gap);
      check("inc_data", key_in, e.data);
    end
    tick();
    check("inc_den_low", key_d_en, 0);
    check("inc_sent300", sent_count, cnt_exp(300));

    // backpressure in FIXED mode
    rst = 1'b1;
    mode = 2'd2;
    fixed_data = 8'h41;
    key_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back('{5, 8'h41});
    wait_key(g);
    e = exp_q.pop_front();
    check("bp_gap", g, e.gap);
    check("bp_data", key_in, e.data);
    for (int n = 2; n <= 11; n++) begin
      tick();
      check("bp_hold_den", key_d_en, 1);
      check("bp_hold_key", key_in, 8'h41);
    end
    key_ready = 1'b1;
    tick();
    check("bp_xfer_den", key_d_en, 0);
    check("bp_key_kept", key_in, 8'h41);
    check("bp_sent", sent_count, cnt_exp(1));

    // enable falls during WAIT: no key
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_d_en) highs++;
    end
    check("wait_abort_pulses", highs, 0);
    check("wait_abort_sent", sent_count, cnt_exp(1));

    // enable falls during PRESENT: key held until accepted, then idle
    enable = 1'b1;
    mode = 2'd3;
    key_ready = 1'b0;
    exp_q.push_back('{5, 8'h41});
    wait_key(g);
    e = exp_q.pop_front();
    check("pres_gap", g, e.gap);
    check("pres_data", key_in, e.data);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pres_hold_den", key_d_en, 1);
    end
    key_ready = 1'b1;
    tick();
    check("pres_xfer_den", key_d_en, 0);
    check("pres_sent", sent_count, cnt_exp(2));
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_d_en) highs++;
    end
    check("pres_idle_pulses", highs, 0);

    // RANDOM mode against the reference LFSR, SEED=1
    rst = 1'b1;
    mode = 2'd0;
    enable = 1'b1;
    key_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lfsr_m = 16'h0001;
    for (int i = 0; i < 1000; i++) begin
      lm = {1'b0, lfsr_m[4:0]} + 6'd1;
      lfsr_m = galois(lfsr_m);
      dm = lfsr_m[12:5];
      if (dm == 8'hFF) dm = 8'h00;
      lfsr_m = galois(lfsr_m);
      exp_q.push_back('{int'(lm) + 1, dm});
      wait_key(g);
      e = exp_q.pop_front();
      check("rnd_gap", g, e.gap);
      check("rnd_gap_range", (g >= 2 && g <= 33), 1);
      check("rnd_not_ff", (key_in != 8'hFF), 1);
      check("rnd_data", key_in, e.data);
    end
    tick();
    check("rnd_sent", sent_count, cnt_exp(1000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_stim_gen.md
# key_stim_gen

Parametrised keyboard-stimulus source for the brainf__k CPU top level. It drives the `key_in`/`key_d_en` input path in random, incrementing or fixed-data modes. Inter-key gaps are either LFSR-random or fixed-programmable, and a ready/valid handshake lets the consumer stall a key. It replaces the free-running single-cycle random key pulser with a synthesizable, reproducible, backpressure-aware generator usable in simulation and on the FPGA board.

## Interface
- `DATA_W`, 8: key data width.
- `LAT_W`, 5: latency field width; gap is 1..2^LAT_W cycles.
- `SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- Constraint: `DATA_W + LAT_W <= 16`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run generator.
- `mode`  in  2  0 RANDOM, 1 INC, 2 FIXED, 3 reserved (behaves as FIXED).
- `lat_cfg`  in  LAT_W  gap is `lat_cfg+1` cycles in INC/FIXED.
- `fixed_data`  in  DATA_W  data in FIXED mode.
- `key_ready`  in  1  consumer accepts the key this cycle.
- `key_in`  out  DATA_W  key data.
- `key_d_en`  out  1  key valid.
- `sent_count`  out  16  accepted keys; saturates at 16'hFFFF.

## Operation
- Reset values: state IDLE, `key_d_en`=0, `key_in`=all-ones, LFSR=`SEED` (or 1), INC counter=0, `sent_count`=0.
- LFSR: 16-bit Galois, taps 16'hB400. It steps exactly once on each entry into WAIT and once on each entry into PRESENT. Fields are sampled from the pre-step value.
- States:
  - IDLE: when `enable`=1, go to WAIT.
  - WAIT: down-counter loaded on entry with L.
    - RANDOM: L = lfsr[LAT_W-1:0]+1.
    - Otherwise: L = `lat_cfg`+1.
    - Decrement each cycle. When the count is 1, go to PRESENT.
    - `enable`=0 in WAIT: go to IDLE next cycle; no key is issued.
  - PRESENT: `key_d_en`=1 and `key_in` is loaded on entry.
    - RANDOM: lfsr[LAT_W+DATA_W-1:LAT_W], with value all-ones replaced by 0.
    - INC: counter value.
    - FIXED: `fixed_data`.
  - Transfer happens when `key_d_en`&&`key_ready` at a rising edge. After transfer: `key_d_en`=0, INC counter +1 (wraps at 2^DATA_W), `sent_count`+1 (saturating), next state WAIT if `enable`, else IDLE.
- `mode`, `lat_cfg` and `fixed_data` are sampled only at WAIT entry (latency) and PRESENT entry (data). Changes mid-state have no effect until the next entry.
- `key_in` keeps its last value while `key_d_en`=0.
- `rst` in any state returns all reset values next edge, including mid-PRESENT; the pending key is dropped and not counted.

## Timing
- `key_d_en` is registered. It rises the cycle after the last WAIT cycle. WAIT lasts exactly L cycles.
- After `rst` deasserts with `enable`=1: 1 IDLE cycle, L WAIT cycles, then `key_d_en` high.
- With `key_ready`=1 constantly: `key_d_en` is a 1-cycle pulse with period L+1. There is at least one low cycle between keys.
- With `key_ready` low: `key_d_en` and `key_in` stay stable until acceptance.
- `enable` falling during PRESENT does not abort the key.

## Configuration
- `KEY_STIM_CNT_EN` defined: `sent_count` is implemented as described.
- Not defined: the counter register is removed and `sent_count` is tied to 0. All other behaviour is identical.

## Structure
- Package `key_stim_pkg` holds:
  - mode enum (`KS_RANDOM`, `KS_INC`, `KS_FIXED`);
  - state enum (`KS_IDLE`, `KS_WAIT`, `KS_PRESENT`);
  - constant `KS_LFSR_TAPS`=16'hB400;
  - the LFSR width constant 16.
- Sub-module `key_stim_lfsr`: a 16-bit Galois LFSR with `step` input, `SEED` parameter and synchronous `rst`. It outputs the current value.

## Test plan
- Reset: hold `rst`=1 for 3 cycles -> `key_d_en`=0, `key_in`=8'hFF, `sent_count`=0 throughout and one cycle after release.
- INC, `lat_cfg`=3, `key_ready`=1 -> first `key_d_en` 5 cycles after reset release (1 IDLE + 4 WAIT). Pulses then repeat every 5 cycles with data 0,1,2,…; key 256 carries 0 again. `sent_count`=300 after 300 keys.
- Backpressure: FIXED, `fixed_data`=8'h41, `key_ready` held low 10 cycles -> `key_d_en`=1 and `key_in`=8'h41 stable for 11 cycles, transfer on the 11th. `sent_count` increments by exactly 1.
- `enable`→0 during WAIT -> IDLE next cycle, no pulse. `enable`→0 during PRESENT -> key held until accepted, then IDLE.
- RANDOM, `SEED`=16'h0001, 1000 keys -> every gap is 1..32 WAIT cycles, `key_in` is never 8'hFF, and the latency/data sequence matches the bench LFSR reference model.
- Build without `KEY_STIM_CNT_EN` -> `sent_count`=0 after 50 keys; the key stream is identical to the build with the macro.
